// File: rtl/alu_ram_pkg.sv
// alu_ram_pkg: shared widths and fill-state encoding for the result RAM writer
package alu_ram_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic [1:0] {IDLE = 2'b00, FILL = 2'b01, FULL = 2'b10} state_t;
endpackage

// File: rtl/ram_16x32_rw.sv
// ram_16x32_rw: register-file RAM, one sync write port, registered read-before-write read port
module ram_16x32_rw #(
  parameter int DATA_W = alu_ram_pkg::DATA_W,
  parameter int ADDR_W = alu_ram_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [1 << ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) rdata <= '0;
    else rdata <= re ? mem[raddr] : '0;
  end
endmodule

// File: rtl/result_ram_writer.sv
// result_ram_writer: captures ALU results via valid/ready into an auto-addressed 16x32 RAM with readback port
module result_ram_writer #(
  parameter int DATA_W = alu_ram_pkg::DATA_W,
  parameter int ADDR_W = alu_ram_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              clear,
  input  logic              en_RAM,
  input  logic [ADDR_W-1:0] addr_RAM,
  output logic [DATA_W-1:0] d,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] wr_addr
);
  import alu_ram_pkg::*;
  localparam logic [ADDR_W:0] last = (ADDR_W + 1)'((1 << ADDR_W) - 1);
  state_t state;
  logic accept;
  assign wr_ready = rst_n && state != FULL;
  assign accept = wr_valid && wr_ready && !clear;
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state <= IDLE;
      count <= '0;
      wr_addr <= '0;
      full <= 1'b0;
    end else if (accept) begin
      state <= count == last ? FULL : FILL;
      full <= count == last;
      count <= count + (ADDR_W + 1)'(1);
      wr_addr <= wr_addr + ADDR_W'(1);
    end
  end
  ram_16x32_rw #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
    .rst_n(rst_n),
    .we(accept),
    .waddr(wr_addr),
    .wdata(wr_data),
    .re(en_RAM),
    .raddr(addr_RAM),
    .rdata(d)
  );
endmodule

// File: tb/tb_result_ram_writer.sv
// tb_result_ram_writer: directed self-checking bench for result_ram_writer
module tb_result_ram_writer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        clear;
  logic        en_RAM;
  logic [3:0]  addr_RAM;
  logic [31:0] d;
  logic        full;
  logic [4:0]  count;
  logic [3:0]  wr_addr;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  result_ram_writer dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_valid(wr_valid),
    .wr_data(wr_data),
    .wr_ready(wr_ready),
    .clear(clear),
    .en_RAM(en_RAM),
    .addr_RAM(addr_RAM),
    .d(d),
    .full(full),
    .count(count),
    .wr_addr(wr_addr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_valid = 1'b1; wr_data = 32'h1111_1111; clear = 1'b0; en_RAM = 1'b1; addr_RAM = 4'd0;
    repeat (3) tick();
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_d got=%h exp=00000000", d); end
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", wr_ready); end
    total++; if (wr_addr !== 4'd0) begin bad++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
    rst_n = 1'b1; wr_valid = 1'b0; en_RAM = 1'b0;
    tick();
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b exp=1", wr_ready); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL release_count got=%0d exp=0", count); end
  endtask

  task automatic test_fill();
    wr_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 32'(4 + 2 * i);
      total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, wr_ready); end
      tick();
    end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", full); end
    total++; if (count !== 5'd16) begin bad++; $display("FAIL fill_count got=%0d exp=16", count); end
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL fill_ready_full got=%b exp=0", wr_ready); end
    total++; if (wr_addr !== 4'd0) begin bad++; $display("FAIL fill_wr_addr got=%0d exp=0", wr_addr); end
    wr_data = 32'hDEAD_BEEF;
    tick();
    total++; if (count !== 5'd16) begin bad++; $display("FAIL full_ignore_count got=%0d exp=16", count); end
    total++; if (wr_addr !== 4'd0) begin bad++; $display("FAIL full_ignore_addr got=%0d exp=0", wr_addr); end
    wr_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      en_RAM = 1'b1; addr_RAM = 4'(i);
      tick();
      total++; if (d !== 32'(4 + 2 * i)) begin bad++; $display("FAIL fill_read[%0d] got=%h exp=%h", i, d, 32'(4 + 2 * i)); end
    end
  endtask

  task automatic test_read_disable();
    en_RAM = 1'b0; addr_RAM = 4'd5;
    tick();
    total++; if (d !== 32'h0) begin bad++; $display("FAIL read_disable got=%h exp=00000000", d); end
  endtask

  task automatic test_gaps();
    logic [8:0] pat;
    int k;
    pat = 9'b101011001;
    k = 0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++; if (count !== 5'd0 || full !== 1'b0) begin bad++; $display("FAIL clear_state got=%0d/%b exp=0/0", count, full); end
    for (int i = 0; i < 9; i++) begin
      wr_valid = pat[i]; wr_data = 32'h100 + 32'(k);
      tick();
      if (pat[i]) k++;
    end
    wr_valid = 1'b0;
    total++; if (count !== 5'd5) begin bad++; $display("FAIL gaps_count got=%0d exp=5", count); end
    total++; if (wr_addr !== 4'd5) begin bad++; $display("FAIL gaps_wr_addr got=%0d exp=5", wr_addr); end
    total++; if (full !== 1'b0 || wr_ready !== 1'b1) begin bad++; $display("FAIL gaps_fill_state got=%b/%b exp=0/1", full, wr_ready); end
    for (int i = 0; i < 5; i++) begin
      en_RAM = 1'b1; addr_RAM = 4'(i);
      tick();
      total++; if (d !== 32'h100 + 32'(i)) begin bad++; $display("FAIL gaps_read[%0d] got=%h exp=%h", i, d, 32'h100 + 32'(i)); end
    end
    en_RAM = 1'b0;
  endtask

  task automatic test_clear_vs_write();
    wr_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wr_data = 32'h200 + 32'(i);
      tick();
    end
    total++; if (count !== 5'd7) begin bad++; $display("FAIL pre_clear_count got=%0d exp=7", count); end
    clear = 1'b1; wr_data = 32'h1234_5678;
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL clear_ready got=%b exp=1", wr_ready); end
    tick();
    clear = 1'b0; wr_valid = 1'b0;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL clear_count got=%0d exp=0", count); end
    total++; if (wr_addr !== 4'd0) begin bad++; $display("FAIL clear_wr_addr got=%0d exp=0", wr_addr); end
    en_RAM = 1'b1; addr_RAM = 4'd7;
    tick();
    total++; if (d !== 32'h12) begin bad++; $display("FAIL clear_mem7 got=%h exp=00000012", d); end
    en_RAM = 1'b0; wr_valid = 1'b1; wr_data = 32'hCAFE_0001;
    tick();
    wr_valid = 1'b0;
    total++; if (count !== 5'd1 || wr_addr !== 4'd1) begin bad++; $display("FAIL after_clear_state got=%0d/%0d exp=1/1", count, wr_addr); end
    en_RAM = 1'b1; addr_RAM = 4'd0;
    tick();
    total++; if (d !== 32'hCAFE_0001) begin bad++; $display("FAIL after_clear_mem0 got=%h exp=cafe0001", d); end
    en_RAM = 1'b0;
  endtask

  task automatic test_collision();
    wr_valid = 1'b1;
    wr_data = 32'h1; tick();
    wr_data = 32'h2; tick();
    wr_data = 32'hAAAA_0000; tick();
    wr_valid = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
    wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 32'h300 + 32'(i);
      tick();
    end
    wr_data = 32'h5555_FFFF; en_RAM = 1'b1; addr_RAM = 4'd3;
    tick();
    wr_valid = 1'b0;
    total++; if (d !== 32'hAAAA_0000) begin bad++; $display("FAIL collision_old got=%h exp=aaaa0000", d); end
    tick();
    total++; if (d !== 32'h5555_FFFF) begin bad++; $display("FAIL collision_new got=%h exp=5555ffff", d); end
  endtask

  task automatic test_reset_mid();
    total++; if (count !== 5'd4) begin bad++; $display("FAIL pre_rst_count got=%0d exp=4", count); end
    rst_n = 1'b0; wr_valid = 1'b1; wr_data = 32'h7777_7777;
    #1;
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b exp=0", wr_ready); end
    tick();
    total++; if (count !== 5'd0 || wr_addr !== 4'd0) begin bad++; $display("FAIL mid_rst_state got=%0d/%0d exp=0/0", count, wr_addr); end
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_rst_d got=%h exp=00000000", d); end
    rst_n = 1'b1; wr_valid = 1'b0; addr_RAM = 4'd4;
    tick();
    total++; if (d !== 32'h104) begin bad++; $display("FAIL mid_rst_mem4 got=%h exp=00000104", d); end
    en_RAM = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_read_disable();
    test_gaps();
    test_clear_vs_write();
    test_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
